// File: rtl/obuf_ctrl_pkg.sv
// obuf_ctrl_pkg: drain FSM states and the FIFO sizing rule shared by the obuf drain logic.
package obuf_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} drain_state_e;
  localparam int FIFO_MIN_SLACK = 2;
  function automatic bit fifo_depth_ok(input int depth, input int latency);
    return depth >= latency + FIFO_MIN_SLACK;
  endfunction
endpackage

// File: rtl/obuf_drain_fifo.sv
// obuf_drain_fifo: synchronous FIFO holding one drained row plus its last tag, with occupancy count.
module obuf_drain_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_pop = pop && count != '0;
  assign do_push = push && count != CW'(DEPTH);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) mem[wr_ptr] <= din;
      if (do_push) wr_ptr <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/obuf_drain_ctrl.sv
// obuf_drain_ctrl: drains num_rows obuf rows across all banks in lockstep into a credit-flow-controlled output stream.
module obuf_drain_ctrl
  import obuf_ctrl_pkg::*;
#(
  parameter int NUM_BANKS = 64,
  parameter int DATA_WIDTH = 8,
  parameter int READ_ADDR_WIDTH = 8,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [READ_ADDR_WIDTH-1:0]           base_addr,
  input  logic [READ_ADDR_WIDTH:0]             num_rows,
  output logic                                 busy,
  output logic                                 done,
  output logic [NUM_BANKS-1:0]                 bs_read_req,
  output logic [NUM_BANKS*READ_ADDR_WIDTH-1:0] bs_read_addr,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]      bs_read_data,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [NUM_BANKS*DATA_WIDTH-1:0]      m_data,
  output logic                                 m_last
);
  localparam int AW = READ_ADDR_WIDTH;
  localparam int RW = NUM_BANKS * DATA_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  if (!fifo_depth_ok(FIFO_DEPTH, READ_LATENCY)) begin : g_depth_check
    $error("obuf_drain_ctrl: FIFO_DEPTH must be at least READ_LATENCY+2");
  end
  drain_state_e state, state_n;
  logic [AW-1:0] base_q, addr_q;
  logic [AW:0] num_q, issued;
  logic [CW-1:0] credit, fifo_count;
  logic [READ_LATENCY-1:0] vpipe, lpipe;
  logic req_q, last_q, done_q, issue, issue_last, fire, head_last;
  assign m_valid = fifo_count != '0;
  assign fire = m_valid && m_ready;
  assign m_last = m_valid && head_last;
  assign busy = state != IDLE;
  assign done = done_q;
  assign bs_read_req = {NUM_BANKS{req_q}};
  assign bs_read_addr = {NUM_BANKS{addr_q}};
  always_comb begin
    state_n = state;
    issue = 1'b0;
    issue_last = 1'b0;
    if (state == IDLE) begin
      issue = start && num_rows != '0;
      issue_last = issue && num_rows == (AW+1)'(1);
      state_n = issue ? RUN : IDLE;
    end else if (state == RUN) begin
      issue = issued != num_q && credit < CW'(FIFO_DEPTH);
      issue_last = issue && issued + (AW+1)'(1) == num_q;
      state_n = issued == num_q ? DRAIN : RUN;
    end else begin
      state_n = fire && m_last ? IDLE : DRAIN;
    end
  end
  // Credits cover both reads still in the bank pipeline and rows parked in the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      base_q <= '0;
      num_q <= '0;
      issued <= '0;
      credit <= '0;
      addr_q <= '0;
      req_q <= 1'b0;
      last_q <= 1'b0;
      vpipe <= '0;
      lpipe <= '0;
      done_q <= 1'b0;
    end else begin
      state <= state_n;
      req_q <= issue;
      last_q <= issue_last;
      vpipe <= READ_LATENCY'({vpipe, req_q});
      lpipe <= READ_LATENCY'({lpipe, last_q});
      if (state == IDLE && issue) base_q <= base_addr;
      if (state == IDLE && issue) num_q <= num_rows;
      if (issue) addr_q <= state == IDLE ? base_addr : base_q + issued[AW-1:0];
      issued <= (state == IDLE ? '0 : issued) + (AW+1)'(issue);
      credit <= credit + CW'(issue) - CW'(fire);
      done_q <= (state == IDLE && start && num_rows == '0) || (state == DRAIN && fire && m_last);
    end
  end
  obuf_drain_fifo #(.WIDTH(RW + 1), .DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk(clk),
    .rst(reset),
    .push(vpipe[READ_LATENCY-1]),
    .din({lpipe[READ_LATENCY-1], bs_read_data}),
    .pop(fire),
    .dout({head_last, m_data}),
    .count(fifo_count)
  );
endmodule

// File: tb/tb_obuf_drain_ctrl.sv
// tb_obuf_drain_ctrl: directed drains against a bank memory model with address and beat scoreboards.
module tb_obuf_drain_ctrl;
  logic clk = 0, reset, start, m_ready;
  logic [7:0] base_addr;
  logic [8:0] num_rows;
  logic busy, done, m_valid, m_last;
  logic [3:0] bs_read_req;
  logic [31:0] bs_read_addr, bs_read_data, m_data;
  int checks = 0, errors = 0, cyc = 0, t0 = 0;
  int reads, beats, first_req, last_req, first_valid, last_beat, done_cnt, done_cyc;
  bit busy_seen, prev_stall;
  logic [31:0] prev_data;
  logic [7:0] aq[$];
  logic [32:0] eq[$];

  obuf_drain_ctrl #(.NUM_BANKS(4), .DATA_WIDTH(8), .READ_ADDR_WIDTH(8), .READ_LATENCY(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_rows(num_rows),
    .busy(busy), .done(done), .bs_read_req(bs_read_req), .bs_read_addr(bs_read_addr),
    .bs_read_data(bs_read_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] bank_word(input logic [7:0] a, input int b);
    logic [1:0] bb;
    bb = 2'(b);
    return a ^ {bb, 6'h15};
  endfunction

  function automatic logic [31:0] row(input logic [7:0] a);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8+:8] = bank_word(a, b);
    return r;
  endfunction

  // Bank model: one-cycle read latency, returns zero when not requested.
  always @(posedge clk)
    for (int b = 0; b < 4; b++)
      bs_read_data[b*8+:8] <= bs_read_req[b] ? bank_word(bs_read_addr[b*8+:8], b) : 8'h00;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (busy) busy_seen = 1;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bs_read_req != 4'h0) begin
        if (reads == 0) first_req = cyc;
        last_req = cyc;
        reads++;
        chk("req_uniform", bs_read_req, 4'hF);
        chk("read_expected", aq.size() != 0, 1);
        if (aq.size() != 0) begin
          logic [7:0] ea;
          ea = aq.pop_front();
          for (int b = 0; b < 4; b++) chk("read_addr", bs_read_addr[b*8+:8], ea);
        end
      end
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (m_valid && prev_stall) chk("hold_data", m_data, prev_data);
      if (m_valid && m_ready) begin
        beats++;
        last_beat = cyc;
        chk("beat_expected", eq.size() != 0, 1);
        if (eq.size() != 0) begin
          logic [32:0] e;
          e = eq.pop_front();
          chk("m_data", m_data, e[31:0]);
          chk("m_last", m_last, e[32]);
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
    end
  end

  task automatic clear_stats();
    reads = 0; beats = 0; first_req = -1; last_req = -1; first_valid = -1;
    last_beat = -1; done_cnt = 0; done_cyc = -1; busy_seen = 0; prev_stall = 0;
  endtask

  task automatic launch(input logic [7:0] b, input logic [8:0] n, input bit accept);
    if (accept)
      for (int i = 0; i < int'(n); i++) begin
        aq.push_back(8'(b + 8'(i)));
        eq.push_back({i == int'(n) - 1, row(8'(b + 8'(i)))});
      end
    start = 1; base_addr = b; num_rows = n; t0 = cyc;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && done_cnt == 0; i++) @(negedge clk);
    chk("done_seen", done_cnt != 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_req"}, bs_read_req, 0);
    chk({tag, "_addr"}, bs_read_addr, 0);
    chk({tag, "_valid"}, m_valid, 0);
    chk({tag, "_last"}, m_last, 0);
  endtask

  initial begin
    reset = 1; start = 0; base_addr = 0; num_rows = 0; m_ready = 1;
    clear_stats();
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    reset = 0;
    @(negedge clk);
    // full-throughput drain
    clear_stats();
    launch(8'h10, 9'd8, 1);
    wait_done();
    chk("tp_first_req", first_req - t0, 1);
    chk("tp_req_span", last_req - first_req, 7);
    chk("tp_reads", reads, 8);
    chk("tp_first_valid", first_valid - t0, 3);
    chk("tp_beat_span", last_beat - first_valid, 7);
    chk("tp_beats", beats, 8);
    chk("tp_done_cyc", done_cyc - t0, 11);
    chk("tp_done_cnt", done_cnt, 1);
    chk("tp_idle", busy, 0);
    chk("tp_sb_empty", eq.size(), 0);
    // backpressure stall then release
    clear_stats();
    m_ready = 0;
    launch(8'h10, 9'd8, 1);
    repeat (12) @(negedge clk);
    chk("bp_stall_reads", reads, 4);
    chk("bp_stall_beats", beats, 0);
    chk("bp_stall_valid", m_valid, 1);
    chk("bp_stall_busy", busy, 1);
    m_ready = 1;
    wait_done();
    chk("bp_reads", reads, 8);
    chk("bp_beats", beats, 8);
    chk("bp_sb_empty", eq.size(), 0);
    // address wrap
    clear_stats();
    launch(8'hFE, 9'd4, 1);
    wait_done();
    chk("wrap_reads", reads, 4);
    chk("wrap_beats", beats, 4);
    chk("wrap_addr_sb", aq.size(), 0);
    // zero-length drain
    clear_stats();
    launch(8'h55, 9'd0, 1);
    wait_done();
    chk("zero_done_cyc", done_cyc - t0, 1);
    chk("zero_reads", reads, 0);
    chk("zero_busy_seen", busy_seen, 0);
    chk("zero_beats", beats, 0);
    // reset mid-drain
    clear_stats();
    launch(8'h20, 9'd8, 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk_quiet("midrst");
    aq.delete();
    eq.delete();
    reset = 0;
    clear_stats();
    repeat (4) @(negedge clk);
    chk("midrst_no_capture", m_valid, 0);
    chk("midrst_no_reads", reads, 0);
    launch(8'h30, 9'd5, 1);
    wait_done();
    chk("fresh_reads", reads, 5);
    chk("fresh_beats", beats, 5);
    chk("fresh_sb_empty", eq.size(), 0);
    // start while busy is ignored
    clear_stats();
    launch(8'h10, 9'd8, 1);
    @(negedge clk);
    launch(8'h40, 9'd3, 0);
    wait_done();
    repeat (5) @(negedge clk);
    chk("busy_start_reads", reads, 8);
    chk("busy_start_beats", beats, 8);
    chk("busy_start_done_cnt", done_cnt, 1);
    chk("busy_start_idle", busy, 0);
    chk("busy_start_sb_empty", aq.size() + eq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/obuf_drain_ctrl.md
OBUF_DRAIN_CTRL -- requirements
Module: obuf_drain_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line; all SHALL be honoured as follows:
  NUM_BANKS, 64, number of obuf banks read in lockstep.
  DATA_WIDTH, 8, bits per bank word.
  READ_ADDR_WIDTH, 8, per-bank read address width.
  READ_LATENCY, 1, cycles from bs_read_req to valid bs_read_data.
  FIFO_DEPTH, 4, output FIFO entries; minimum READ_LATENCY+2.
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk, in, 1, single clock; all state on rising edge.
  reset, in, 1, synchronous, active-high.
  start, in, 1, launch a drain; sampled only in IDLE.
  base_addr, in, READ_ADDR_WIDTH, first row address.
  num_rows, in, READ_ADDR_WIDTH+1, rows to drain (0..2^READ_ADDR_WIDTH).
  busy, out, 1, drain in progress.
  done, out, 1, one-cycle completion pulse.
  bs_read_req, out, NUM_BANKS, per-bank read enable to obuf.
  bs_read_addr, out, NUM_BANKS*READ_ADDR_WIDTH, per-bank read address.
  bs_read_data, in, NUM_BANKS*DATA_WIDTH, bank read data.
  m_valid, out, 1, output beat valid.
  m_ready, in, 1, downstream accept.
  m_data, out, NUM_BANKS*DATA_WIDTH, one row, all banks.
  m_last, out, 1, final beat of the drain.

Function
REQ-003 FSM states IDLE, RUN, DRAIN; IDLE->RUN on start with num_rows!=0; RUN->DRAIN when issued==num_rows; DRAIN->IDLE on the handshake (m_valid&&m_ready) of the m_last beat.
REQ-004 start with num_rows==0 in IDLE SHALL produce done=1 the next cycle, stay IDLE, issue no reads.
REQ-005 start while busy SHALL be ignored; base_addr/num_rows latched only on accepted start.
REQ-006 All NUM_BANKS bits of bs_read_req SHALL be identical; all bank address fields SHALL equal base_addr+issued, modulo 2^READ_ADDR_WIDTH (wrap silently).
REQ-007 bs_read_req and bs_read_addr SHALL be registered; first request at cycle T+1 for start accepted at cycle T.
REQ-008 Credit counter = reads in flight + FIFO occupancy; a read issues in RUN only when credit < FIFO_DEPTH; issue+pop in the same cycle leaves credit unchanged; FIFO SHALL never overflow.
REQ-009 Read-return tracking: READ_LATENCY-deep valid shift register; bs_read_data captured into FIFO exactly READ_LATENCY cycles after its request.
REQ-010 m_valid = FIFO non-empty; m_data = FIFO head; beat pops on m_valid&&m_ready; m_data stable while m_valid&&!m_ready.
REQ-011 m_last SHALL accompany the num_rows-th beat only, tagged in the FIFO entry.
REQ-012 With m_ready held 1, reads SHALL issue every cycle (full throughput); first m_valid at T+2+READ_LATENCY.
REQ-013 busy = state!=IDLE; done pulses the cycle after the m_last handshake, same cycle busy falls.

Reset
REQ-014 Reset SHALL force IDLE, clear counters, credits, latency pipe and FIFO; outputs busy, done, bs_read_req, m_valid, m_last = 0, bs_read_addr = 0.
REQ-015 Reset mid-drain SHALL discard in-flight/FIFO data; data returning after reset SHALL not be captured.

Structure
REQ-016 Shared package obuf_ctrl_pkg SHALL hold the FSM state enum and the FIFO_DEPTH minimum-check constant.
REQ-017 One sub-module obuf_drain_fifo (synchronous FIFO, data+last, count output) SHALL be instantiated; FSM, counters and credit logic stay in obuf_drain_ctrl.

Verification (NUM_BANKS=4, DATA_WIDTH=8, READ_ADDR_WIDTH=8, READ_LATENCY=1, FIFO_DEPTH=4)
REQ-018 start at T, base=0x10, num=8, m_ready=1 -> reads 0x10..0x17 at T+1..T+8, m_valid from T+3, 8 beats back-to-back, m_last on beat 8, done at T+11.
REQ-019 Same drain, m_ready=0 -> exactly 4 reads issued then stall; release m_ready -> all 8 rows delivered in order, none lost or duplicated.
REQ-020 base=0xFE, num=4 -> addresses 0xFE,0xFF,0x00,0x01; m_last on 4th beat.
REQ-021 num=0 -> done at T+1, bs_read_req never asserted, busy stays 0.
REQ-022 reset at T+3 of a num=8 drain -> next cycle all outputs 0, state IDLE; fresh start completes normally with correct data.
REQ-023 start pulsed with base=0x40 during an active drain -> ignored; original address sequence and beat count unchanged.
